// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
// Central stall/flush controller for the 5-stage flowCPU_mips pipeline.
//   - Merges the ID load-use stall, EX multi-cycle ops and exception flushes.
//   - Drives the per-stage hold vector {wb, mem_wb, ex_mem, id_ex, if_id, PC}.
//   - Sequences multi-cycle EX ops with an internal down-counter.
//   - Issues a registered flush pulse with its redirect address to fetch.
// Priority, highest first: flush request > EX multi-cycle > ID load-use.
//
// Optional build macro: PIPE_PERF_EN
//   When defined, adds the stall_cycles and flush_count performance
//   counters (32-bit, saturating, cleared by rst) as extra output ports.
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int unsigned CYC_W    = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_stallreq,
  input  logic             ex_mc_start,
  input  logic [CYC_W-1:0] ex_mc_cycles,
  input  logic             flush_req,
  input  logic [31:0]      flush_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             ex_mc_done,
  output logic             busy
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
`endif
);

  // Hold patterns: each one freezes the requesting stage and everything
  // upstream of it, while downstream stages keep draining.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [CYC_W-1:0] CNT_ZERO = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0] CNT_ONE  = CYC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cnt_q,   cnt_d;
  logic             flush_q, flush_d;
  logic [31:0]      new_pc_q, new_pc_d;

  // Unmasked combinational outputs; reset masking is applied afterwards.
  logic [5:0]       stall_raw;
  logic             done_raw;

  // Next-state logic plus the combinational stall/done decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flush_d   = 1'b0;
    new_pc_d  = new_pc_q;
    stall_raw = STALL_NONE;
    done_raw  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          // Exception redirect: freeze everything this cycle, then flush.
          stall_raw = STALL_ALL;
          state_d   = ST_FLUSH;
          new_pc_d  = flush_pc;
          flush_d   = 1'b1;
        end else if (ex_mc_start) begin
          if (ex_mc_cycles != CNT_ZERO) begin
            // This cycle is the first of N held cycles, so N-1 remain.
            stall_raw = STALL_EX;
            cnt_d     = ex_mc_cycles - CNT_ONE;
            state_d   = ST_MC_BUSY;
          end else begin
            // Zero-length op completes immediately without holding.
            done_raw  = 1'b1;
          end
        end else if (id_stallreq) begin
          stall_raw = STALL_ID;
        end else begin
          stall_raw = STALL_NONE;
        end
      end

      ST_MC_BUSY: begin
        if (flush_req) begin
          // Abort the multi-cycle op; its result is discarded.
          stall_raw = STALL_ALL;
          cnt_d     = CNT_ZERO;
          state_d   = ST_FLUSH;
          new_pc_d  = flush_pc;
          flush_d   = 1'b1;
        end else if (cnt_q != CNT_ZERO) begin
          // The EX hold already covers the ID load-use hazard.
          stall_raw = STALL_EX;
          cnt_d     = cnt_q - CNT_ONE;
        end else begin
          // Last cycle: release the pipe so the EX result advances.
          // A new ex_mc_start is deliberately not accepted here.
          done_raw  = 1'b1;
          stall_raw = STALL_NONE;
          state_d   = ST_IDLE;
        end
      end

      ST_FLUSH: begin
        if (flush_req) begin
          // A newer redirect replaces the pending one and extends the flush.
          new_pc_d = flush_pc;
          flush_d  = 1'b1;
          state_d  = ST_FLUSH;
        end else begin
          flush_d  = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        flush_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered flush/new_pc outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      flush_q  <= 1'b0;
      new_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Combinational outputs are forced quiet while reset is asserted so an
  // interrupted op never produces a spurious done or hold.
  always_comb begin
    if (rst) begin
      stall      = STALL_NONE;
      ex_mc_done = 1'b0;
      busy       = 1'b0;
    end else begin
      stall      = stall_raw;
      ex_mc_done = done_raw;
      busy       = (state_q != ST_IDLE);
    end
  end

  assign flush  = flush_q;
  assign new_pc = new_pc_q;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    if (val == 32'hFFFF_FFFF) begin
      sat_inc = val;
    end else begin
      sat_inc = val + 32'd1;
    end
  endfunction

  // Performance counters for stalled cycles and flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (stall != STALL_NONE) begin
        stall_cycles_q <= sat_inc(stall_cycles_q);
      end else begin
        stall_cycles_q <= stall_cycles_q;
      end
      if (flush_q) begin
        flush_count_q <= sat_inc(flush_count_q);
      end else begin
        flush_count_q <= flush_count_q;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for pipe_stall_ctrl: directed scenarios with fixed
// expected values, then randomized traffic against a timestamp-based model.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;
  localparam int          CYC_W    = 6;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_stallreq = 1'b0;
  logic             ex_mc_start = 1'b0;
  logic [CYC_W-1:0] ex_mc_cycles = '0;
  logic             flush_req = 1'b0;
  logic [31:0]      flush_pc = 32'd0;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             ex_mc_done;
  logic             busy;
`ifdef PIPE_PERF_EN
  logic [31:0]      stall_cycles;
  logic [31:0]      flush_count;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stall_ctrl #(.CYC_W(CYC_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .id_stallreq(id_stallreq), .ex_mc_start(ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .ex_mc_done(ex_mc_done),
    .busy(busy)
`ifdef PIPE_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs at the falling edge; outputs are read 1ns later.
  task automatic drive(input logic r, input logic i, input logic s, input int n,
                       input logic f, input logic [31:0] pc);
    @(negedge clk);
    rst = r; id_stallreq = i; ex_mc_start = s; ex_mc_cycles = n[CYC_W-1:0];
    flush_req = f; flush_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 32'd0);
    checks++; if (stall !== 6'b000000 || busy !== 1'b0 || ex_mc_done !== 1'b0) begin
      errors++; $display("FAIL reset_held stall=%b busy=%b done=%b expected 000000/0/0", stall, busy, ex_mc_done); end
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 32'd0);
    checks++; if (stall !== 6'b000000 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release stall=%b busy=%b expected 000000/0", stall, busy); end
    checks++; if (flush !== 1'b0 || new_pc !== RESET_PC) begin
      errors++; $display("FAIL reset_regs flush=%b new_pc=%h expected 0/%h", flush, new_pc, RESET_PC); end
  endtask

  task automatic test_id_stall();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 1'b0, 0, 1'b0, 32'd0);
      checks++; if (stall !== 6'b000111 || busy !== 1'b0) begin
        errors++; $display("FAIL id_stall cyc%0d stall=%b busy=%b expected 000111/0", c, stall, busy); end
    end
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 32'd0);
    checks++; if (stall !== 6'b000000 || busy !== 1'b0) begin
      errors++; $display("FAIL id_stall_end stall=%b busy=%b expected 000000/0", stall, busy); end
  endtask

  task automatic test_mc_op();
    logic [5:0] e_stall;
    logic       e_done, e_busy;
    for (int t = 0; t <= 5; t++) begin
      drive(1'b0, 1'b0, (t == 0), 4, 1'b0, 32'd0);
      e_stall = (t < 4) ? 6'b001111 : 6'b000000;
      e_done  = (t == 4);
      e_busy  = (t >= 1 && t <= 4);
      checks++; if (stall !== e_stall || ex_mc_done !== e_done || busy !== e_busy) begin
        errors++; $display("FAIL mc_op_n4 t%0d stall=%b done=%b busy=%b expected %b/%b/%b",
                           t, stall, ex_mc_done, busy, e_stall, e_done, e_busy); end
    end
    drive(1'b0, 1'b0, 1'b1, 0, 1'b0, 32'd0);
    checks++; if (stall !== 6'b000000 || ex_mc_done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mc_op_n0 stall=%b done=%b busy=%b expected 000000/1/0", stall, ex_mc_done, busy); end
  endtask

  task automatic test_flush_abort();
    int done_seen = 0;
    for (int t = 0; t < 3; t++) begin
      drive(1'b0, 1'b0, (t == 0), 10, 1'b0, 32'd0);
      if (ex_mc_done === 1'b1) done_seen++;
    end
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'hBFC0_0380);
    if (ex_mc_done === 1'b1) done_seen++;
    checks++; if (stall !== 6'b111111) begin
      errors++; $display("FAIL flush_abort_t3 stall=%b expected 111111", stall); end
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 32'd0);
    if (ex_mc_done === 1'b1) done_seen++;
    checks++; if (flush !== 1'b1 || new_pc !== 32'hBFC0_0380 || stall !== 6'b000000 || busy !== 1'b1) begin
      errors++; $display("FAIL flush_abort_t4 flush=%b new_pc=%h stall=%b busy=%b expected 1/bfc00380/000000/1",
                         flush, new_pc, stall, busy); end
    for (int t = 5; t < 16; t++) begin
      drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 32'd0);
      if (ex_mc_done === 1'b1) done_seen++;
      if (t == 5) begin
        checks++; if (flush !== 1'b0 || busy !== 1'b0 || new_pc !== 32'hBFC0_0380) begin
          errors++; $display("FAIL flush_abort_t5 flush=%b busy=%b new_pc=%h expected 0/0/bfc00380", flush, busy, new_pc); end
      end
    end
    checks++; if (done_seen != 0) begin
      errors++; $display("FAIL flush_abort_done done_pulses=%0d expected 0", done_seen); end
  endtask

  task automatic test_flush_in_flush();
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h1111_0000);
    drive(1'b0, 1'b1, 1'b1, 3, 1'b1, 32'h2222_0000);
    checks++; if (flush !== 1'b1 || new_pc !== 32'h1111_0000 || stall !== 6'b000000 || ex_mc_done !== 1'b0) begin
      errors++; $display("FAIL flush_repeat_a flush=%b new_pc=%h stall=%b expected 1/11110000/000000", flush, new_pc, stall); end
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 32'd0);
    checks++; if (flush !== 1'b1 || new_pc !== 32'h2222_0000) begin
      errors++; $display("FAIL flush_repeat_b flush=%b new_pc=%h expected 1/22220000", flush, new_pc); end
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 32'd0);
    checks++; if (flush !== 1'b0 || new_pc !== 32'h2222_0000 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_repeat_c flush=%b new_pc=%h busy=%b expected 0/22220000/0", flush, new_pc, busy); end
  endtask

  task automatic test_priority();
    drive(1'b0, 1'b1, 1'b1, 3, 1'b0, 32'd0);
    checks++; if (stall !== 6'b001111) begin
      errors++; $display("FAIL prio_ex_over_id stall=%b expected 001111", stall); end
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0, 32'd0);
    checks++; if (stall !== 6'b001111 || ex_mc_done !== 1'b0) begin
      errors++; $display("FAIL prio_mc_hold stall=%b done=%b expected 001111/0", stall, ex_mc_done); end
    drive(1'b0, 1'b1, 1'b1, 2, 1'b0, 32'd0);
    checks++; if (stall !== 6'b000000 || ex_mc_done !== 1'b1) begin
      errors++; $display("FAIL prio_mc_done stall=%b done=%b expected 000000/1", stall, ex_mc_done); end
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 32'd0);
    checks++; if (busy !== 1'b0 || stall !== 6'b000000) begin
      errors++; $display("FAIL prio_no_restart busy=%b stall=%b expected 0/000000", busy, stall); end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    for (int t = 0; t < 3; t++) drive(1'b0, 1'b0, (t == 0), 8, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 32'd0);
    checks++; if (stall !== 6'b000000 || busy !== 1'b0 || ex_mc_done !== 1'b0) begin
      errors++; $display("FAIL reset_mid_held stall=%b busy=%b done=%b expected 000000/0/0", stall, busy, ex_mc_done); end
    for (int t = 0; t < 8; t++) begin
      drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 32'd0);
      if (ex_mc_done === 1'b1) done_seen++;
      if (t == 0) begin
        checks++; if (stall !== 6'b000000 || busy !== 1'b0 || flush !== 1'b0) begin
          errors++; $display("FAIL reset_mid_after stall=%b busy=%b flush=%b expected 000000/0/0", stall, busy, flush); end
      end
    end
    checks++; if (done_seen != 0) begin
      errors++; $display("FAIL reset_mid_done done_pulses=%0d expected 0", done_seen); end
  endtask

`ifdef PIPE_PERF_EN
  task automatic test_perf();
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 32'd0);
    for (int t = 0; t <= 5; t++) drive(1'b0, 1'b0, (t == 0), 4, 1'b0, 32'd0);
    checks++; if (stall_cycles !== 32'd4 || flush_count !== 32'd0) begin
      errors++; $display("FAIL perf_stall stall_cycles=%0d flush_count=%0d expected 4/0", stall_cycles, flush_count); end
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0040);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 32'd0);
    checks++; if (stall_cycles !== 32'd5 || flush_count !== 32'd1) begin
      errors++; $display("FAIL perf_flush stall_cycles=%0d flush_count=%0d expected 5/1", stall_cycles, flush_count); end
  endtask
`endif

  // Random traffic. The model tracks an in-flight op only by the cycle number
  // on which it must complete, plus the pending flush and redirect address.
  task automatic test_random();
    bit          m_flush = 1'b0;
    logic [31:0] m_pc = RESET_PC;
    bit          m_pend = 1'b0;
    int          m_done_at = 0;
    logic [5:0]  e_stall;
    logic        e_done, e_busy;
    logic        r, i, s, f;
    int          n;
    logic [31:0] pc;
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 32'd0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r  = ($urandom_range(0, 99) == 0);
      i  = ($urandom_range(0, 2) == 0);
      s  = ($urandom_range(0, 3) == 0);
      n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 5));
      f  = ($urandom_range(0, 11) == 0);
      pc = $urandom;
      drive(r, i, s, n, f, pc);
      e_stall = 6'b000000; e_done = 1'b0; e_busy = 1'b0;
      if (r) begin
        e_busy = 1'b0;
      end else if (m_flush) begin
        e_busy = 1'b1;
      end else if (m_pend) begin
        e_busy = 1'b1;
        if (f) e_stall = 6'b111111;
        else if (cyc == m_done_at) e_done = 1'b1;
        else e_stall = 6'b001111;
      end else begin
        if (f) e_stall = 6'b111111;
        else if (s && n > 0) e_stall = 6'b001111;
        else if (s) e_done = 1'b1;
        else if (i) e_stall = 6'b000111;
      end
      checks++; if (stall !== e_stall || ex_mc_done !== e_done || busy !== e_busy) begin
        errors++; $display("FAIL rand_comb cyc%0d stall=%b done=%b busy=%b expected %b/%b/%b",
                           cyc, stall, ex_mc_done, busy, e_stall, e_done, e_busy); end
      checks++; if (flush !== m_flush || new_pc !== m_pc) begin
        errors++; $display("FAIL rand_regs cyc%0d flush=%b new_pc=%h expected %b/%h", cyc, flush, new_pc, m_flush, m_pc); end
      if (r) begin
        m_flush = 1'b0; m_pc = RESET_PC; m_pend = 1'b0;
      end else if (m_flush) begin
        if (f) m_pc = pc;
        else m_flush = 1'b0;
      end else if (f) begin
        m_flush = 1'b1; m_pc = pc; m_pend = 1'b0;
      end else if (m_pend) begin
        if (cyc == m_done_at) m_pend = 1'b0;
      end else if (s && n > 0) begin
        m_pend = 1'b1; m_done_at = cyc + n;
      end
    end
  endtask

  initial begin
    test_reset();
    test_id_stall();
    test_mc_op();
    test_flush_abort();
    test_flush_in_flush();
    test_priority();
    test_reset_mid();
`ifdef PIPE_PERF_EN
    test_perf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
